ram3_mem: RTL and testbench



---
 rtl/ram3_pkg.sv | 9 +
 rtl/ram3_array.sv | 22 ++
 rtl/ram3_mem.sv | 53 +++++
 tb/tb_ram3_mem.sv | 123 ++++++++++++
 4 files changed

// File: rtl/ram3_pkg.sv
// ram3_pkg: shared sizes, word/address types and output-source encoding for ram3_mem.
package ram3_pkg;
    localparam int RAM3_ADDR_W = 10;
    localparam int RAM3_DATA_W = 8;
    localparam int RAM3_DEPTH  = 1 << RAM3_ADDR_W;
    typedef logic [RAM3_ADDR_W-1:0] ram3_addr_t;
    typedef logic [RAM3_DATA_W-1:0] ram3_data_t;
    typedef enum logic [1:0] {SRC_ZERO, SRC_ARR, SRC_WT} ram3_src_e;
endpackage

// File: rtl/ram3_array.sv
// ram3_array: plain un-reset storage with synchronous write and registered read,
// kept separate so it can be replaced by a vendor macro.
module ram3_array import ram3_pkg::*; #(
    parameter int ADDR_W = RAM3_ADDR_W,
    parameter int DATA_W = RAM3_DATA_W,
    parameter int DEPTH  = 1 << ADDR_W
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_q;
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_addr] <= i_wdata;
        if (i_re) r_q <= r_mem[i_addr];
    end
    assign o_rdata = r_q;
endmodule

// File: rtl/ram3_mem.sv
// ram3_mem: 1024x8 single-port RAM with valid map so unwritten words read as 0.
// Optional RAM3_WRITE_THROUGH_EN: written data also appears on data_out after the write edge.
module ram3_mem import ram3_pkg::*; #(
    parameter int ADDR_W = RAM3_ADDR_W,
    parameter int DATA_W = RAM3_DATA_W,
    parameter int DEPTH  = 1 << ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out
);
    logic              w_we;
    logic              w_re;
    logic [DATA_W-1:0] w_rdata;
    logic [DEPTH-1:0]  r_valid;
    ram3_src_e         r_src;
    // The array has no reset, so accesses are gated while rst is held to abort them.
    assign w_we = cs & wr & ~rst;
    assign w_re = cs & ~wr & ~rst;
    ram3_array #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) u_array (
        .clk     (clk),
        .i_we    (w_we),
        .i_re    (w_re),
        .i_addr  (addr),
        .i_wdata (data_in),
        .o_rdata (w_rdata)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_valid <= '0;
        else if (w_we) r_valid[addr] <= 1'b1;
    end
    // data_out is a mux of registered sources; resetting the selector zeroes it at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_src <= SRC_ZERO;
        else if (w_re) r_src <= r_valid[addr] ? SRC_ARR : SRC_ZERO;
`ifdef RAM3_WRITE_THROUGH_EN
        else if (w_we) r_src <= SRC_WT;
`endif
    end
`ifdef RAM3_WRITE_THROUGH_EN
    logic [DATA_W-1:0] r_wt;
    always_ff @(posedge clk) begin
        if (w_we) r_wt <= data_in;
    end
    always_comb data_out = (r_src == SRC_ARR) ? w_rdata : (r_src == SRC_WT) ? r_wt : '0;
`else
    always_comb data_out = (r_src == SRC_ARR) ? w_rdata : '0;
`endif
endmodule

// File: tb/tb_ram3_mem.sv
// tb_ram3_mem: directed plan plus random traffic checked against an array-based model.
module tb_ram3_mem;
    logic       clk = 1'b0;
    logic       rst;
    logic       cs;
    logic       wr;
    logic [9:0] addr;
    logic [7:0] data_in;
    logic [7:0] data_out;
    int checks = 0;
    int errors = 0;
    logic [7:0] m_mem [1024];
    bit         m_val [1024];
    logic [7:0] m_out;

    ram3_mem dut (
        .clk      (clk),
        .rst      (rst),
        .cs       (cs),
        .wr       (wr),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 1024; i++) m_val[i] = 1'b0;
        m_out = 8'h00;
    endtask

    task automatic step(input string tag, input logic c, input logic w,
                        input logic [9:0] a, input logic [7:0] d);
        cs = c; wr = w; addr = a; data_in = d;
        @(posedge clk);
        if (c && w) begin
            m_mem[a] = d;
            m_val[a] = 1'b1;
`ifdef RAM3_WRITE_THROUGH_EN
            m_out = d;
`endif
        end else if (c) begin
            m_out = m_val[a] ? m_mem[a] : 8'h00;
        end
        #1;
        check(tag, data_out, m_out);
    endtask

    initial begin
        rst = 1'b1; cs = 1'b0; wr = 1'b0; addr = '0; data_in = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_dout", data_out, 8'h00);
        rst = 1'b0;
        step("rd0_after_reset", 1, 0, 10'd0, 8'h00);
        step("wr2", 1, 1, 10'd2, 8'd4);
        step("rd2", 1, 0, 10'd2, 8'h00);
        check("rd2_value", data_out, 8'd4);
        step("rd4_unwritten", 1, 0, 10'd4, 8'd8);
        step("rd4_again", 1, 0, 10'd4, 8'h00);
        check("rd4_zero", data_out, 8'h00);
        step("wr12_cs0", 0, 1, 10'd12, 8'd10);
        step("rd12_none", 1, 0, 10'd12, 8'h00);
        check("rd12_zero", data_out, 8'h00);
        step("wr12", 1, 1, 10'd12, 8'd10);
        step("rd12", 1, 0, 10'd12, 8'h00);
        check("rd12_value", data_out, 8'd10);
        step("wr0", 1, 1, 10'd0, 8'hA5);
        step("wr1023", 1, 1, 10'd1023, 8'h5A);
        step("rd0", 1, 0, 10'd0, 8'h00);
        check("rd0_value", data_out, 8'hA5);
        step("rd1023", 1, 0, 10'd1023, 8'h00);
        check("rd1023_value", data_out, 8'h5A);
        step("idle_hold", 0, 0, 10'd2, 8'hFF);
        step("rd2_again", 1, 0, 10'd2, 8'h00);
        check("rd2_still4", data_out, 8'd4);
        // Async reset between edges, held across a write that must be aborted.
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("async_rst_dout", data_out, 8'h00);
        cs = 1'b1; wr = 1'b1; addr = 10'd3; data_in = 8'h77;
        @(posedge clk);
        #1;
        check("rst_write_dout", data_out, 8'h00);
        cs = 1'b0;
        #2;
        rst = 1'b0;
        step("rd2_after_rst", 1, 0, 10'd2, 8'h00);
        step("rd12_after_rst", 1, 0, 10'd12, 8'h00);
        step("rd3_aborted", 1, 0, 10'd3, 8'h00);
        check("rd3_zero", data_out, 8'h00);
        step("wr2_restore", 1, 1, 10'd2, 8'h11);
        step("rd2_restore", 1, 0, 10'd2, 8'h00);
        step("wr7", 1, 1, 10'd7, 8'h3C);
`ifdef RAM3_WRITE_THROUGH_EN
        check("wr7_through", data_out, 8'h3C);
`else
        check("wr7_hold", data_out, 8'h11);
`endif
        for (int i = 0; i < 400; i++) begin
            logic       c, w;
            logic [9:0] a;
            c = ($urandom_range(0, 9) != 0);
            w = $urandom_range(0, 1) == 1;
            a = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(0, 31));
            step("random", c, w, a, 8'($urandom));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
